lifo_burst_reader: RTL and testbench

Downstream consumer for the `lifo` stack. On a start pulse it latches the LIFO occupancy and pops exactly that many words. The LIFO has a registered read with 1-cycle latency; the block re-times its output into a valid/ready stream with burst framing. A 2-entry skid buffer sustains 1 word/cycle under backpressure without losing in-flight reads.

---
 rtl/lifo_burst_reader.sv | 114 +++++++++++
 tb/tb_lifo_burst_reader.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lifo_burst_reader.sv
// Pops a latched number of words from a registered-read LIFO and re-times them into a
// valid/ready stream with last framing, using a 2-entry skid buffer to absorb read latency.
module lifo_burst_reader #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              lifo_empty_i,
  input  logic [AWIDTH:0]   lifo_usedw_i,
  input  logic [DWIDTH-1:0] lifo_q_i,
  output logic              lifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i
);

  localparam int unsigned CW = AWIDTH + 1;

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     req_cnt_q, req_cnt_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic              inflight_q;
  logic [DWIDTH-1:0] buf_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        occ_q;
  logic              done_q, done_d;

  logic              hs;
  logic              last_hs;
  logic              start_ok;
  logic              start_empty;
  logic [1:0]        pending;
  logic              credit;

  assign hs          = valid_o & ready_i;
  assign last_hs     = hs & (out_cnt_q == CW'(1));
  assign start_ok    = (state_q == StIdle) & start_i & (lifo_usedw_i != '0);
  assign start_empty = (state_q == StIdle) & start_i & (lifo_usedw_i == '0);
  assign pending     = occ_q + {1'b0, inflight_q};
  // A word leaving this cycle frees its slot in time for the next write, keeping 1 word/cycle.
  assign credit      = (pending < 2'd2) | ((pending == 2'd2) & hs);

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_ok) state_d = StBurst;
      StBurst: if (last_hs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy_o       = (state_q == StBurst);
    lifo_rdreq_o = (state_q == StBurst) & (req_cnt_q != '0) & ~lifo_empty_i & credit;
    valid_o      = (occ_q != 2'd0);
    data_o       = buf_q[rd_ptr_q];
    last_o       = valid_o & (out_cnt_q == CW'(1));
    done_o       = done_q;
  end

  always_comb begin
    req_cnt_d = req_cnt_q;
    out_cnt_d = out_cnt_q;
    done_d    = start_empty | last_hs;
    if (start_ok) begin
      req_cnt_d = lifo_usedw_i;
      out_cnt_d = lifo_usedw_i;
    end else begin
      if (lifo_rdreq_o) req_cnt_d = req_cnt_q - CW'(1);
      if (hs)           out_cnt_d = out_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      req_cnt_q  <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= 2'd0;
    end else begin
      req_cnt_q  <= req_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      inflight_q <= lifo_rdreq_o;
      if (inflight_q) begin
        buf_q[wr_ptr_q] <= lifo_q_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (hs) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, hs};
    end
  end

endmodule

// File: tb/tb_lifo_burst_reader.sv
// Directed bench for lifo_burst_reader with a behavioural LIFO and an output scoreboard.
module tb_lifo_burst_reader;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          srst, start, busy, done, rdreq, valid, last, ready;
  logic [DW-1:0] data;

  // behavioural LIFO with registered read
  logic [DW-1:0] stack [8];
  logic [AW:0]   cnt = '0;
  logic [DW-1:0] lifo_q = '0;
  logic          push_en;
  logic [DW-1:0] push_data;
  logic          lifo_empty;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;
  exp_t sb [$];

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0, last_cnt = 0, outstanding = 0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev = '0;

  int b_hs, b_rd, b_done, b_last, n;

  always #5 clk = ~clk;

  assign lifo_empty = (cnt == '0);

  lifo_burst_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i        (clk),
    .srst_i       (srst),
    .start_i      (start),
    .busy_o       (busy),
    .done_o       (done),
    .lifo_empty_i (lifo_empty),
    .lifo_usedw_i (cnt),
    .lifo_q_i     (lifo_q),
    .lifo_rdreq_o (rdreq),
    .data_o       (data),
    .valid_o      (valid),
    .last_o       (last),
    .ready_i      (ready)
  );

  always @(posedge clk) begin
    if (rdreq && cnt != '0) begin
      lifo_q <= stack[cnt - 1];
      cnt    <= cnt - 1'b1;
    end else if (push_en && cnt < 4'd8) begin
      stack[cnt[AW-1:0]] <= push_data;
      cnt                <= cnt + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (srst) begin
      outstanding <= 0;
      stall_prev  <= 1'b0;
    end else begin
      if (busy) chk("outstanding", 32'((outstanding <= 2)), 1);
      if (rdreq) chk("rdreq_while_empty", lifo_empty, 0);
      if (stall_prev) begin
        chk("stall_valid", valid, 1);
        chk("stall_data", data, data_prev);
      end
      if (valid && ready) begin
        chk("sb_has_entry", 32'((sb.size() != 0)), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data", data, e.data);
          chk("last", last, e.last);
        end
        hs_cnt <= hs_cnt + 1;
        if (last) last_cnt <= last_cnt + 1;
      end
      if (done)  done_cnt <= done_cnt + 1;
      if (rdreq) rd_cnt <= rd_cnt + 1;
      outstanding <= outstanding + int'(rdreq) - int'(valid && ready);
      stall_prev  <= valid & ~ready;
      data_prev   <= data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    push_en   = 1'b1;
    push_data = d;
    step();
    push_en   = 1'b0;
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++) push(8'(8'h11 * i));
  endtask

  task automatic load_sb();
    for (int i = int'(cnt) - 1; i >= 0; i--) sb.push_back('{data: stack[i], last: (i == 0)});
  endtask

  task automatic snap();
    b_hs = hs_cnt; b_rd = rd_cnt; b_done = done_cnt; b_last = last_cnt;
  endtask

  task automatic wait_done(input int max, output int steps);
    steps = 0;
    while (!done && steps < max) begin
      step();
      steps++;
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rdreq"}, rdreq, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_data"}, data, 0);
  endtask

  task automatic burst_end(input int words);
    step();
    chk("done_pulse_width", done, 0);
    chk("busy_after", busy, 0);
    chk("hs_count", hs_cnt - b_hs, words);
    chk("last_count", last_cnt - b_last, 1);
    chk("done_count", done_cnt - b_done, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  initial begin
    srst = 1'b1; start = 1'b0; ready = 1'b1; push_en = 1'b0; push_data = '0;
    #1;
    check_zero_outputs("reset");
    step();
    srst = 1'b0;
    step();

    // full burst, ready held high
    fill8();
    snap();
    load_sb();
    start = 1'b1;
    step();
    chk("busy_after_start", busy, 1);
    chk("first_rdreq", rdreq, 1);
    chk("valid_e0", valid, 0);
    start = 1'b0;
    step();
    chk("valid_e1", valid, 0);
    step();
    chk("valid_e2", valid, 1);
    chk("first_word", data, 8'h88);
    wait_done(40, n);
    chk("burst_cycles", n, 8);
    burst_end(8);
    chk("lifo_empty_after", cnt, 0);
    chk("rd_count_full", rd_cnt - b_rd, 8);

    // ready toggling
    fill8();
    snap();
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      ready = ~ready;
      step();
      n++;
    end
    chk("toggle_done", done, 1);
    ready = 1'b1;
    burst_end(8);

    // long backpressure: only two reads may be outstanding
    fill8();
    snap();
    load_sb();
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    chk("bp_reads", rd_cnt - b_rd, 2);
    chk("bp_valid", valid, 1);
    chk("bp_data", data, 8'h88);
    chk("bp_usedw", cnt, 6);
    ready = 1'b1;
    wait_done(40, n);
    burst_end(8);

    // empty LIFO start
    snap();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_rdreq", rdreq, 0);
    chk("empty_valid", valid, 0);
    step();
    chk("empty_done_clear", done, 0);
    chk("empty_reads", rd_cnt - b_rd, 0);
    chk("empty_words", hs_cnt - b_hs, 0);

    // start re-pulsed mid-burst is ignored
    push(8'hA1);
    push(8'hA2);
    push(8'hA3);
    snap();
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, n);
    burst_end(3);

    // asynchronous reset after two handshakes
    fill8();
    snap();
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while ((hs_cnt - b_hs) < 2 && n < 20) begin
      step();
      n++;
    end
    chk("rst_hs_timeout", hs_cnt - b_hs, 2);
    srst = 1'b1;
    #1;
    check_zero_outputs("async_rst");
    sb.delete();
    step();
    srst = 1'b0;
    chk("usedw_at_reset", cnt, 4);
    snap();
    load_sb();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(40, n);
    burst_end(4);
    chk("lifo_empty_final", cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
